airi5c_spi_slave: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, fully in the CLK domain: oversamples SCLK/NSS/MOSI, no SCLK-clocked flops.

---
 rtl/airi5c_spi_slave.sv | 202 ++++++++++++++++++++
 tb/tb_airi5c_spi_slave.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/airi5c_spi_slave.sv
// SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, oversampled entirely in the CLK domain.
// Core handshakes: a word moves on every CLK edge where valid and ready are both high.
module airi5c_spi_slave #(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_DUMMY    = 8'hFF
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    input  logic                  spi_sclk,
    input  logic                  spi_nss,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int unsigned          CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] nss_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_dly_q;
    logic                   nss_dly_q;

    state_e                  state_q,        state_d;
    logic [CNT_W-1:0]        bit_cnt_q,      bit_cnt_d;
    logic [DATA_WIDTH-2:0]   rx_shift_q,     rx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q,     tx_shift_d;
    logic [DATA_WIDTH-1:0]   tx_buf_q,       tx_buf_d;
    logic                    tx_buf_valid_q, tx_buf_valid_d;
    logic [DATA_WIDTH-1:0]   rx_data_q,      rx_data_d;
    logic                    rx_valid_q,     rx_valid_d;
    logic                    miso_oe_q,      miso_oe_d;
    logic                    rx_overrun_q,   rx_overrun_d;
    logic                    tx_underrun_q,  tx_underrun_d;
    logic                    load_pend_q,    load_pend_d;

    logic                  sclk_s, nss_s, mosi_s;
    logic                  sclk_rise, sclk_fall, nss_rise, nss_fall;
    logic                  word_load;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [DATA_WIDTH-1:0] load_word;

    // The NSS chain resets high so a released reset never looks like a select.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            sclk_sync_q <= '0;
            nss_sync_q  <= '1;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            nss_dly_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            nss_sync_q  <= {nss_sync_q[SYNC_STAGES-2:0], spi_nss};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_dly_q  <= sclk_sync_q[SYNC_STAGES-1];
            nss_dly_q   <= nss_sync_q[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign nss_s     = nss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly_q;
    assign sclk_fall = ~sclk_s & sclk_dly_q;
    assign nss_rise  = nss_s & ~nss_dly_q;
    assign nss_fall  = ~nss_s & nss_dly_q;
    assign rx_word   = {rx_shift_q, mosi_s};
    assign load_word = tx_buf_valid_q ? tx_buf_q : TX_DUMMY;

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        tx_buf_d       = tx_buf_q;
        tx_buf_valid_d = tx_buf_valid_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        miso_oe_d      = miso_oe_q;
        load_pend_d    = load_pend_q;
        rx_overrun_d   = 1'b0;
        tx_underrun_d  = 1'b0;
        word_load      = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        // A capture never bypasses into a load happening in the same cycle.
        if (tx_valid && !tx_buf_valid_q) begin
            tx_buf_d       = tx_data;
            tx_buf_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                bit_cnt_d = '0;
                if (nss_fall) begin
                    state_d   = S_ACTIVE;
                    word_load = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (nss_rise) begin
                    state_d     = S_IDLE;
                    bit_cnt_d   = '0;
                    rx_shift_d  = '0;
                    tx_shift_d  = '0;
                    miso_oe_d   = 1'b0;
                    load_pend_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = rx_word[DATA_WIDTH-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d   = '0;
                        load_pend_d = 1'b1;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = rx_word;
                            rx_valid_d = 1'b1;
                        end else begin
                            rx_overrun_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (load_pend_q) begin
                        word_load = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (word_load) begin
            tx_shift_d    = load_word;
            tx_underrun_d = ~tx_buf_valid_q;
            miso_oe_d     = 1'b1;
            load_pend_d   = 1'b0;
            if (tx_buf_valid_q) begin
                tx_buf_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            tx_buf_q       <= '0;
            tx_buf_valid_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            miso_oe_q      <= 1'b0;
            rx_overrun_q   <= 1'b0;
            tx_underrun_q  <= 1'b0;
            load_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            tx_buf_q       <= tx_buf_d;
            tx_buf_valid_q <= tx_buf_valid_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            miso_oe_q      <= miso_oe_d;
            rx_overrun_q   <= rx_overrun_d;
            tx_underrun_q  <= tx_underrun_d;
            load_pend_q    <= load_pend_d;
        end
    end

    // MISO is the shift register MSB; the register is cleared whenever the slave is idle.
    assign spi_miso    = tx_shift_q[DATA_WIDTH-1];
    assign spi_miso_oe = miso_oe_q;
    assign tx_ready    = ~tx_buf_valid_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_airi5c_spi_slave.sv
// Bench for airi5c_spi_slave: a mode-0 SPI master model drives random and fixed words,
// expectations come from word-level rules (MISO = buffered word or 0xFF, RX = MOSI word).
module tb_airi5c_spi_slave;

    localparam int W    = 8;
    localparam int HALF = 10;   // CLK cycles per SCLK half period (sclk 400 ns at CLK 20 ns)

    logic         CLK      = 1'b0;
    logic         nRESET   = 1'b0;
    logic         spi_sclk = 1'b0;
    logic         spi_nss  = 1'b1;
    logic         spi_mosi = 1'b0;
    logic         spi_miso;
    logic         spi_miso_oe;
    logic [W-1:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready = 1'b0;
    logic         rx_overrun;
    logic         tx_underrun;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int und_cnt = 0;
    int ovr_cnt = 0;
    bit oe_low_seen = 1'b0;
    logic [W-1:0] got_q[$];
    logic [W-1:0] exp_q[$];

    airi5c_spi_slave dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .spi_sclk   (spi_sclk),
        .spi_nss    (spi_nss),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_overrun (rx_overrun),
        .tx_underrun(tx_underrun),
        .busy       (busy)
    );

    // ---------------- clock / reset ----------------
    always #10 CLK = ~CLK;

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1);
    end

    // ---------------- monitors ----------------
    always @(negedge CLK) begin
        if (nRESET) begin
            if (tx_underrun) und_cnt++;
            if (rx_overrun) ovr_cnt++;
            if (rx_valid && rx_ready) got_q.push_back(rx_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic half_period();
        repeat (HALF) @(negedge CLK);
    endtask

    task automatic settle();
        repeat (8) @(negedge CLK);
    endtask

    task automatic load_tx(input logic [W-1:0] d);
        int t;
        t = 0;
        @(negedge CLK);
        while (!tx_ready && t < 2000) begin
            @(negedge CLK);
            t++;
        end
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tx_ready_wait: got %b, required 1 within 2000 cycles", tx_ready);
        end
        @(posedge CLK);
        #1 tx_valid = 1'b1;
        tx_data = d;
        @(posedge CLK);
        #1 tx_valid = 1'b0;
    endtask

    task automatic accept_rx();
        @(posedge CLK);
        #1 rx_ready = 1'b1;
        @(posedge CLK);
        #1 rx_ready = 1'b0;
        @(negedge CLK);
    endtask

    task automatic drain_rx();
        @(negedge CLK);
        if (rx_valid) accept_rx();
    endtask

    task automatic frame_begin();
        @(negedge CLK);
        spi_nss = 1'b0;
    endtask

    // Each bit: SCLK falls (except on the first bit of a frame), MOSI changes, MISO is
    // sampled just before SCLK rises. The frame ends with NSS rising while SCLK is high.
    task automatic xfer_bits(input logic [W-1:0] mo, input int nbits, input bit first,
                             output logic [W-1:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!(first && i == 0)) spi_sclk = 1'b0;
            spi_mosi = mo[W-1-i];
            half_period();
            if (!spi_miso_oe) oe_low_seen = 1'b1;
            mi[W-1-i] = spi_miso;
            spi_sclk = 1'b1;
            half_period();
        end
    endtask

    task automatic frame_end();
        spi_nss = 1'b1;
        half_period();
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        half_period();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        nRESET = 1'b0;
        repeat (3) @(negedge CLK);
        n_vec++;
        if ({spi_miso, spi_miso_oe, rx_valid, rx_overrun, tx_underrun, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got miso/oe/rxv/ovr/und/busy=%b, required 000000",
                     {spi_miso, spi_miso_oe, rx_valid, rx_overrun, tx_underrun, busy});
        end
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_tx_ready: got %b, required 1", tx_ready);
        end
        n_vec++;
        if (rx_data !== '0) begin
            n_err++;
            $display("FAIL reset_rx_data: got %h, required 00", rx_data);
        end
        nRESET = 1'b1;
        settle();
        n_vec++;
        if ({busy, spi_miso_oe, tx_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL post_reset_idle: got busy/oe/tx_ready=%b, required 001",
                     {busy, spi_miso_oe, tx_ready});
        end
    endtask

    task automatic test_single_word(input logic [W-1:0] txw, input logic [W-1:0] mow);
        logic [W-1:0] mi;
        int u0, o0;
        drain_rx();
        load_tx(txw);
        @(negedge CLK);
        n_vec++;
        if (tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL tx_ready_full: got %b, required 0", tx_ready);
        end
        u0 = und_cnt;
        o0 = ovr_cnt;
        oe_low_seen = 1'b0;
        frame_begin();
        xfer_bits(mow, W, 1'b1, mi);
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_active: got %b, required 1", busy);
        end
        frame_end();
        settle();
        n_vec++;
        if (mi !== txw) begin
            n_err++;
            $display("FAIL miso_word: got %h, required %h", mi, txw);
        end
        n_vec++;
        if (oe_low_seen !== 1'b0) begin
            n_err++;
            $display("FAIL miso_oe_active: got oe low during transfer, required high");
        end
        n_vec++;
        if ({rx_valid, rx_data} !== {1'b1, mow}) begin
            n_err++;
            $display("FAIL rx_word: got valid=%b data=%h, required valid=1 data=%h",
                     rx_valid, rx_data, mow);
        end
        n_vec++;
        if ((und_cnt - u0) != 0 || (ovr_cnt - o0) != 0) begin
            n_err++;
            $display("FAIL no_pulses: got underrun=%0d overrun=%0d, required 0 0",
                     und_cnt - u0, ovr_cnt - o0);
        end
        n_vec++;
        if ({busy, spi_miso_oe, spi_miso, tx_ready} !== 4'b0001) begin
            n_err++;
            $display("FAIL idle_after_frame: got busy/oe/miso/tx_ready=%b, required 0001",
                     {busy, spi_miso_oe, spi_miso, tx_ready});
        end
        accept_rx();
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rx_accept: got rx_valid=%b, required 0", rx_valid);
        end
    endtask

    task automatic test_underrun();
        logic [W-1:0] mi, mow;
        int u0;
        mow = W'($urandom_range(0, 255));
        drain_rx();
        n_vec++;
        if (tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_empty: got tx_ready=%b, required 1", tx_ready);
        end
        u0 = und_cnt;
        frame_begin();
        xfer_bits(mow, W, 1'b1, mi);
        frame_end();
        settle();
        n_vec++;
        if (mi !== 8'hFF) begin
            n_err++;
            $display("FAIL underrun_miso: got %h, required ff", mi);
        end
        n_vec++;
        if (und_cnt - u0 != 1) begin
            n_err++;
            $display("FAIL underrun_pulse: got %0d cycles, required 1", und_cnt - u0);
        end
        n_vec++;
        if (rx_data !== mow) begin
            n_err++;
            $display("FAIL underrun_rx: got %h, required %h", rx_data, mow);
        end
    endtask

    task automatic test_overrun();
        logic [W-1:0] mi;
        int u0, o0;
        drain_rx();
        u0 = und_cnt;
        o0 = ovr_cnt;
        frame_begin();
        xfer_bits(8'h11, W, 1'b1, mi);
        xfer_bits(8'h22, W, 1'b0, mi);
        frame_end();
        settle();
        n_vec++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h11}) begin
            n_err++;
            $display("FAIL overrun_keep: got valid=%b data=%h, required valid=1 data=11",
                     rx_valid, rx_data);
        end
        n_vec++;
        if (ovr_cnt - o0 != 1) begin
            n_err++;
            $display("FAIL overrun_pulse: got %0d cycles, required 1", ovr_cnt - o0);
        end
        n_vec++;
        if (und_cnt - u0 != 2) begin
            n_err++;
            $display("FAIL overrun_underruns: got %0d, required 2", und_cnt - u0);
        end
        accept_rx();
        n_vec++;
        if (rx_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_accept: got rx_valid=%b, required 0", rx_valid);
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] mi, txw;
        int o0, u0;
        txw = W'($urandom_range(0, 255));
        drain_rx();
        o0 = ovr_cnt;
        u0 = und_cnt;
        frame_begin();
        xfer_bits(W'($urandom_range(0, 255)), 5, 1'b1, mi);
        frame_end();
        settle();
        n_vec++;
        if ({rx_valid, busy, spi_miso_oe} !== 3'b000) begin
            n_err++;
            $display("FAIL abort_idle: got rxv/busy/oe=%b, required 000",
                     {rx_valid, busy, spi_miso_oe});
        end
        n_vec++;
        if ((ovr_cnt - o0) != 0 || (und_cnt - u0) != 1) begin
            n_err++;
            $display("FAIL abort_pulses: got overrun=%0d underrun=%0d, required 0 1",
                     ovr_cnt - o0, und_cnt - u0);
        end
        load_tx(txw);
        frame_begin();
        xfer_bits(8'h5A, W, 1'b1, mi);
        frame_end();
        settle();
        n_vec++;
        if ({rx_valid, rx_data} !== {1'b1, 8'h5A}) begin
            n_err++;
            $display("FAIL abort_next_rx: got valid=%b data=%h, required valid=1 data=5a",
                     rx_valid, rx_data);
        end
        n_vec++;
        if (mi !== txw) begin
            n_err++;
            $display("FAIL abort_next_miso: got %h, required %h", mi, txw);
        end
        accept_rx();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] tw [4];
        logic [W-1:0] mw [4];
        logic [W-1:0] mis [4];
        logic [W-1:0] got, exp_w;
        int g0, u0, o0;
        for (int i = 0; i < 4; i++) begin
            tw[i] = W'($urandom_range(0, 255));
            mw[i] = W'($urandom_range(0, 255));
            exp_q.push_back(mw[i]);
        end
        drain_rx();
        @(posedge CLK);
        #1 rx_ready = 1'b1;
        g0 = got_q.size();
        load_tx(tw[0]);
        u0 = und_cnt;
        o0 = ovr_cnt;
        fork
            begin
                for (int i = 1; i < 4; i++) load_tx(tw[i]);
            end
            begin
                frame_begin();
                for (int i = 0; i < 4; i++) begin
                    logic [W-1:0] mi;
                    xfer_bits(mw[i], W, (i == 0), mi);
                    mis[i] = mi;
                end
                frame_end();
            end
        join
        settle();
        @(posedge CLK);
        #1 rx_ready = 1'b0;
        n_vec++;
        if (got_q.size() - g0 != 4) begin
            n_err++;
            $display("FAIL b2b_rx_count: got %0d, required 4", got_q.size() - g0);
        end
        for (int i = 0; i < 4; i++) begin
            exp_w = exp_q.pop_front();
            got = (g0 + i < got_q.size()) ? got_q[g0 + i] : 'x;
            n_vec++;
            if (got !== exp_w) begin
                n_err++;
                $display("FAIL b2b_rx[%0d]: got %h, required %h", i, got, exp_w);
            end
            n_vec++;
            if (mis[i] !== tw[i]) begin
                n_err++;
                $display("FAIL b2b_miso[%0d]: got %h, required %h", i, mis[i], tw[i]);
            end
        end
        n_vec++;
        if ((und_cnt - u0) != 0 || (ovr_cnt - o0) != 0) begin
            n_err++;
            $display("FAIL b2b_pulses: got underrun=%0d overrun=%0d, required 0 0",
                     und_cnt - u0, ovr_cnt - o0);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] mi;
        drain_rx();
        load_tx(W'($urandom_range(0, 255)));
        frame_begin();
        xfer_bits(W'($urandom_range(0, 255)), 3, 1'b1, mi);
        n_vec++;
        if (spi_miso_oe !== 1'b1) begin
            n_err++;
            $display("FAIL mid_oe_before: got %b, required 1", spi_miso_oe);
        end
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        n_vec++;
        if ({spi_miso_oe, busy, tx_ready} !== 3'b001) begin
            n_err++;
            $display("FAIL mid_reset_async: got oe/busy/tx_ready=%b, required 001",
                     {spi_miso_oe, busy, tx_ready});
        end
        spi_nss  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        settle();
        n_vec++;
        if ({rx_valid, tx_ready, spi_miso_oe} !== 3'b010) begin
            n_err++;
            $display("FAIL mid_reset_release: got rxv/tx_ready/oe=%b, required 010",
                     {rx_valid, tx_ready, spi_miso_oe});
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        test_reset();
        test_single_word(8'hA5, 8'h3C);
        for (int k = 0; k < 5; k++) begin
            test_single_word(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
        test_underrun();
        test_overrun();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_single_word(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
